// File: rtl/mealy_stream_ctrl.sv
// mealy_stream_ctrl: loads a frame, clears the detector, streams it MSB-first and counts detector hits
module mealy_stream_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_stall,
  input  logic             i_z_in,
  output logic             o_x_out,
  output logic             o_det_en,
  output logic             o_det_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_bit_idx,
  output logic [3:0]       o_seq
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_idx;
  logic [3:0]       r_seq;
  wire w_accept = (r_state == IDLE) && i_start;
  wire w_adv    = (r_state == SHIFT) && !i_stall;
  wire w_last   = r_idx == CNT_W'(WIDTH - 1);
  // state sequencing; a frame ends on the edge that consumes its last bit
  always_ff @(posedge i_clk)
    if (!i_reset) r_state <= IDLE;
    else r_state <= w_accept ? LOAD :
                    (r_state == LOAD) ? SHIFT :
                    (w_adv && w_last) ? DONE :
                    (r_state == DONE) ? IDLE : r_state;
  // frame register: captured on accept, shifted left once per enabled bit
  always_ff @(posedge i_clk)
    if (!i_reset) r_sreg <= '0;
    else if (w_accept) r_sreg <= i_din;
    else if (w_adv) r_sreg <= r_sreg << 1;
  // per-frame statistics: cleared in LOAD, advanced per enabled bit, held otherwise
  always_ff @(posedge i_clk)
    if (!i_reset || r_state == LOAD) begin
      r_hit <= '0;
      r_idx <= '0;
      r_seq <= '0;
    end else if (w_adv) begin
      r_hit <= r_hit + CNT_W'(i_z_in);
      r_idx <= r_idx + 1'b1;
      r_seq <= {r_seq[2:0], r_sreg[WIDTH-1]};
    end
  assign o_x_out   = (r_state == SHIFT) && r_sreg[WIDTH-1];
  assign o_det_en  = w_adv;
  assign o_det_rst = r_state != LOAD;
  assign o_busy    = r_state != IDLE;
  assign o_done    = r_state == DONE;
  assign o_hit_cnt = r_hit;
  assign o_bit_idx = r_idx;
  assign o_seq     = r_seq;
endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// tb_mealy_stream_ctrl: randomized frames checked against a pattern-count reference
module tb_mealy_stream_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, stall, z;
  logic [15:0] din;
  logic        x_out, det_en, det_rst, busy, done;
  logic [4:0]  hit_cnt, bit_idx;
  logic [3:0]  seq;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [2:0]  hist;

  mealy_stream_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_din(din), .i_stall(stall),
    .i_z_in(z), .o_x_out(x_out), .o_det_en(det_en), .o_det_rst(det_rst),
    .o_busy(busy), .o_done(done), .o_hit_cnt(hit_cnt), .o_bit_idx(bit_idx), .o_seq(seq)
  );

  always #5 clk = ~clk;

  // overlapping "1011" Mealy detector driven by the DUT's serial output
  always @(posedge clk)
    if (!reset || !det_rst) hist <= 3'b000;
    else if (det_en) hist <= {hist[1:0], x_out};
  assign z = x_out && (hist == 3'b101);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // number of "1011" windows among the first n bits sent MSB-first
  function automatic int hits(input logic [15:0] d, input int n);
    int c = 0;
    for (int i = 3; i < n; i++)
      if ({d[18-i], d[17-i], d[16-i], d[15-i]} == 4'b1011) c++;
    return c;
  endfunction

  // last four bits sent after n bits, newest in bit 0
  function automatic logic [3:0] last4(input logic [15:0] d, input int n);
    logic [31:0] t;
    t = {16'b0, d} >> (16 - n);
    return t[3:0];
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_x"}, x_out, 0);
    chk({tag, "_en"}, det_en, 0);
    chk({tag, "_rst"}, det_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // call while IDLE before the rising edge; returns at the falling edge of the following IDLE cycle
  task automatic run_frame(input logic [15:0] d, input int pct, input int s_at, input int s_len,
                           input logic hold);
    int n = 0;
    int cyc = 0;
    int sl = s_len;
    start = 1'b1;
    din = d;
    stall = 1'b0;
    @(posedge clk); #1;
    start = hold;
    din = 16'($urandom);
    @(negedge clk);
    chk("load_rst", det_rst, 0);
    chk("load_en", det_en, 0);
    chk("load_busy", busy, 1);
    chk("load_x", x_out, 0);
    chk("load_done", done, 0);
    @(posedge clk); #1;
    while (n < 16 && cyc < 400) begin
      if (n == s_at && sl > 0) begin
        stall = 1'b1;
        sl--;
      end else stall = ($urandom_range(0, 99) < pct);
      din = 16'($urandom);
      @(negedge clk);
      chk("sh_en", det_en, !stall);
      chk("sh_x", x_out, d[15-n]);
      chk("sh_idx", bit_idx, n);
      chk("sh_hit", hit_cnt, hits(d, n));
      chk("sh_seq", seq, last4(d, n));
      chk("sh_busy", busy, 1);
      chk("sh_done", done, 0);
      chk("sh_rst", det_rst, 1);
      if (!stall) n++;
      cyc++;
      @(posedge clk); #1;
    end
    chk("frame_budget", cyc < 400, 1);
    stall = $urandom_range(0, 1);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_en", det_en, 0);
    chk("done_x", x_out, 0);
    chk("done_hit", hit_cnt, hits(d, 16));
    chk("done_idx", bit_idx, 16);
    chk("done_seq", seq, d[3:0]);
    @(posedge clk); #1;
    start = hold;
    stall = $urandom_range(0, 1);
    @(negedge clk);
    idle_chk("gap");
    chk("hold_hit", hit_cnt, hits(d, 16));
    chk("hold_idx", bit_idx, 16);
    chk("hold_seq", seq, d[3:0]);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("por");
    chk("por_hit", hit_cnt, 0);
    chk("por_idx", bit_idx, 0);
    chk("por_seq", seq, 0);
    reset = 1'b1;
    @(negedge clk);
    run_frame(16'hBBBB, 0, -1, 0, 1'b0);
    run_frame(16'h0000, 0, -1, 0, 1'b0);
    run_frame(16'hB0B0, 0, -1, 0, 1'b0);
    run_frame(16'hBBBB, 0, 8, 3, 1'b0);
    run_frame(16'hBBBB, 0, 15, 2, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(16'($urandom), 20, -1, 0, 1'b1);
    run_frame(16'hDB6D, 0, -1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      run_frame(16'($urandom), 30, $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    din = 16'hBBBB;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      idle_chk("rst_mid");
      chk("rst_mid_hit", hit_cnt, 0);
      chk("rst_mid_idx", bit_idx, 0);
      chk("rst_mid_seq", seq, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      idle_chk("post_rst");
    end
    run_frame(16'hBBBB, 0, -1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
